sine_rom_sequencer: RTL and testbench

Controller that drives the sine-wave ROM read port from the sample-rate tick. On each tick it advances a phase accumulator and issues one ROM read at the address taken from the phase MSBs. It captures the returned word and presents it downstream on a valid/ready handshake. It sits between the tick counter and the ROM and replaces the free-running address counter.

---
 rtl/sine_seq_pkg.sv | 17 +
 rtl/sine_rom_sequencer_if.sv | 26 ++
 rtl/sine_rom_sequencer_phase_acc.sv | 31 +++
 rtl/sine_rom_sequencer.sv | 163 ++++++++++++++++
 tb/tb_sine_rom_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sine_seq_pkg.sv
// Shared types and default widths for the sine ROM sequencer.
package sine_seq_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 6;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_PHASE_WIDTH = 16;
    localparam int unsigned BURST_LEN_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        READ,
        CAPTURE,
        HOLD
    } state_e;

endpackage

// File: rtl/sine_rom_sequencer_if.sv
// ROM read port plus downstream sample valid/ready handshake.
interface sine_rom_sequencer_if
    import sine_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_address;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] sample_data;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output rom_en, rom_address, sample_data, sample_valid,
        input  rom_data, sample_ready
    );

    modport slave (
        input  rom_en, rom_address, sample_data, sample_valid,
        output rom_data, sample_ready
    );

endinterface

// File: rtl/sine_rom_sequencer_phase_acc.sv
// Phase accumulator: clearable, adds the step when enabled, wraps modulo 2^PHASE_WIDTH.
module phase_acc
    import sine_seq_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic                   i_en,
    input  logic [PHASE_WIDTH-1:0] i_step,
    output logic [ADDR_WIDTH-1:0]  o_addr
);

    logic [PHASE_WIDTH-1:0] r_phase;

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (i_clear) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= r_phase + i_step;
        end
    end

    assign o_addr = r_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];

endmodule

// File: rtl/sine_rom_sequencer.sv
// Tick-driven sine ROM read sequencer with valid/ready sample output.
// Optional burst mode (burst_len / done) enabled by defining SINE_BURST_EN.
module sine_rom_sequencer
    import sine_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_tick,
    input  logic [PHASE_WIDTH-1:0] i_step,
`ifdef SINE_BURST_EN
    input  logic [BURST_LEN_WIDTH-1:0] i_burst_len,
    output logic                       o_done,
`endif
    output logic                   o_busy,
    output logic                   o_overrun,
    sine_rom_sequencer_if.master   bus
);

    state_e                r_state;
    state_e                w_next_state;
    logic                  r_stop_pending;
    logic                  r_overrun;
    logic                  r_rom_en;
    logic [ADDR_WIDTH-1:0] r_rom_address;
    logic [DATA_WIDTH-1:0] r_sample_data;
    logic                  r_sample_valid;
    logic                  r_busy;

    logic                  w_start_acc;
    logic                  w_in_flight;
    logic                  w_handshake;
    logic                  w_stop_seen;
    logic                  w_burst_last;
    logic                  w_rom_en_nxt;
    logic                  w_sample_valid_nxt;
    logic                  w_busy_nxt;
    logic [ADDR_WIDTH-1:0] w_phase_addr;

    assign w_start_acc = (r_state == IDLE) && i_start && !i_stop;
    assign w_in_flight = (r_state == READ) || (r_state == CAPTURE) || (r_state == HOLD);
    assign w_handshake = (r_state == HOLD) && r_sample_valid && bus.sample_ready;
    assign w_stop_seen = r_stop_pending || i_stop;

    phase_acc #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_phase_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start_acc),
        .i_en    (r_state == READ),
        .i_step  (i_step),
        .o_addr  (w_phase_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start && !i_stop) w_next_state = ARMED;
            ARMED: begin
                if (i_stop)      w_next_state = IDLE;
                else if (i_tick) w_next_state = READ;
            end
            READ:    w_next_state = CAPTURE;
            CAPTURE: w_next_state = HOLD;
            HOLD: begin
                if (w_handshake) begin
                    if (w_stop_seen || w_burst_last) w_next_state = IDLE;
                    else                             w_next_state = ARMED;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each is glitch-free.
    always_comb begin
        w_rom_en_nxt       = (w_next_state == READ);
        w_sample_valid_nxt = (w_next_state == HOLD);
        w_busy_nxt         = (w_next_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_en       <= 1'b0;
            r_rom_address  <= '0;
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_rom_en       <= w_rom_en_nxt;
            r_sample_valid <= w_sample_valid_nxt;
            r_busy         <= w_busy_nxt;
            if (w_rom_en_nxt) r_rom_address <= w_phase_addr;
            if (r_state == CAPTURE) r_sample_data <= bus.rom_data;
        end
    end

    // A stop arriving mid-sample is remembered so the sample still completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stop_pending <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (r_state == IDLE)            r_stop_pending <= 1'b0;
            else if (i_stop && w_in_flight) r_stop_pending <= 1'b1;

            if (w_start_acc)                r_overrun <= 1'b0;
            else if (i_tick && w_in_flight) r_overrun <= 1'b1;
        end
    end

`ifdef SINE_BURST_EN
    logic [BURST_LEN_WIDTH-1:0] r_burst_len;
    logic [BURST_LEN_WIDTH-1:0] r_burst_cnt;
    logic                       r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_len <= '0;
            r_burst_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_handshake && w_burst_last;
            if (w_start_acc) begin
                r_burst_len <= i_burst_len;
                r_burst_cnt <= '0;
            end else if (w_handshake) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
        end
    end

    // A zero length never matches, giving unlimited generation.
    assign w_burst_last = (r_burst_len != '0) && (r_burst_cnt == r_burst_len - 16'd1);
    assign o_done       = r_done;
`else
    assign w_burst_last = 1'b0;
`endif

    assign bus.rom_en       = r_rom_en;
    assign bus.rom_address  = r_rom_address;
    assign bus.sample_data  = r_sample_data;
    assign bus.sample_valid = r_sample_valid;
    assign o_busy           = r_busy;
    assign o_overrun        = r_overrun;

endmodule

// File: tb/tb_sine_rom_sequencer.sv
// Directed bench for sine_rom_sequencer; inputs driven and outputs sampled on the falling edge.
module tb_sine_rom_sequencer;
    import sine_seq_pkg::*;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int PW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          tick  = 1'b0;
    logic [PW-1:0] step  = '0;
    logic          busy;
    logic          overrun;
`ifdef SINE_BURST_EN
    logic [15:0]   burst_len = '0;
    logic          done;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sine_rom_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sine_rom_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PHASE_WIDTH(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_stop      (stop),
        .i_tick      (tick),
        .i_step      (step),
`ifdef SINE_BURST_EN
        .i_burst_len (burst_len),
        .o_done      (done),
`endif
        .o_busy      (busy),
        .o_overrun   (overrun),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [5:0] a);
        return {8'hC0, 2'b00, a, 16'h1234 ^ {10'd0, a}};
    endfunction

    // ROM model: registered read, data valid the cycle after rom_en.
    always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom_word(bus.rom_address);

    task automatic test_reset();
        bus.sample_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.rom_en, bus.rom_address, bus.sample_data, bus.sample_valid, busy, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b addr=%0d data=%h valid=%b busy=%b ovr=%b want all 0",
                     bus.rom_en, bus.rom_address, bus.sample_data, bus.sample_valid, busy, overrun);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL start_stop_idle busy: got %b want 0", busy); end
    endtask

    // Runs ticks every (4 + gap) cycles and checks the full tick-to-accept timing.
    task automatic test_sweep(input string name, input logic [PW-1:0] stp, input int n, input int dir, input int gap);
        logic [5:0] ea;
        step = stp;
        bus.sample_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || overrun !== 1'b0) begin
            n_err++; $display("FAIL %s start: got busy=%b ovr=%b want 1/0", name, busy, overrun);
        end
        for (int k = 0; k < n; k++) begin
            ea = 6'((64 + dir * k) % 64);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            n_cmp++;
            if (bus.rom_en !== 1'b1 || bus.rom_address !== ea) begin
                n_err++; $display("FAIL %s read[%0d]: got en=%b addr=%0d want 1/%0d", name, k, bus.rom_en, bus.rom_address, ea);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.rom_en !== 1'b0 || bus.sample_valid !== 1'b0) begin
                n_err++; $display("FAIL %s capture[%0d]: got en=%b valid=%b want 0/0", name, k, bus.rom_en, bus.sample_valid);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.sample_valid !== 1'b1 || bus.sample_data !== rom_word(ea)) begin
                n_err++; $display("FAIL %s hold[%0d]: got valid=%b data=%h want 1/%h", name, k, bus.sample_valid, bus.sample_data, rom_word(ea));
            end
            @(negedge clk);
            n_cmp++;
            if (bus.sample_valid !== 1'b0 || busy !== 1'b1 || bus.sample_data !== rom_word(ea)) begin
                n_err++; $display("FAIL %s after[%0d]: got valid=%b busy=%b data=%h want 0/1/%h", name, k, bus.sample_valid, busy, bus.sample_data, rom_word(ea));
            end
            repeat (gap) @(negedge clk);
        end
        n_cmp++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL %s overrun: got %b want 0", name, overrun); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL %s stop: got busy=%b want 0", name, busy); end
    endtask

    task automatic test_basic();
        test_sweep("basic", 16'h0400, 65, 1, 6);
    endtask

    task automatic test_back_to_back();
        test_sweep("b2b", 16'h0400, 4, 1, 0);
    endtask

    task automatic test_wrap();
        test_sweep("wrap", 16'hFC00, 5, -1, 2);
    endtask

    task automatic test_backpressure();
        step = 16'h0400;
        bus.sample_ready = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.sample_valid !== 1'b1 || bus.sample_data !== rom_word(6'd0)) begin
            n_err++; $display("FAIL bp_hold: got valid=%b data=%h want 1/%h", bus.sample_valid, bus.sample_data, rom_word(6'd0));
        end
        repeat (5) @(negedge clk);
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        n_cmp++;
        if (overrun !== 1'b1 || bus.sample_valid !== 1'b1 || bus.rom_en !== 1'b0) begin
            n_err++; $display("FAIL bp_drop: got ovr=%b valid=%b en=%b want 1/1/0", overrun, bus.sample_valid, bus.rom_en);
        end
        repeat (13) @(negedge clk);
        n_cmp++;
        if (bus.sample_valid !== 1'b1 || bus.sample_data !== rom_word(6'd0)) begin
            n_err++; $display("FAIL bp_stable: got valid=%b data=%h want 1/%h", bus.sample_valid, bus.sample_data, rom_word(6'd0));
        end
        bus.sample_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.sample_valid !== 1'b0) begin n_err++; $display("FAIL bp_accept: got valid=%b want 0", bus.sample_valid); end
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        n_cmp++;
        if (bus.rom_en !== 1'b1 || bus.rom_address !== 6'd1) begin
            n_err++; $display("FAIL bp_next_addr: got en=%b addr=%0d want 1/1", bus.rom_en, bus.rom_address);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b1) begin n_err++; $display("FAIL bp_sticky: got %b want 1", overrun); end
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        n_cmp++;
        if (overrun !== 1'b1) begin n_err++; $display("FAIL bp_sticky_idle: got %b want 1", overrun); end
        start = 1'b1; @(negedge clk); start = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL bp_clear: got ovr=%b busy=%b want 0/1", overrun, busy);
        end
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic test_stop();
        int stray;
        step = 16'h0400;
        bus.sample_ready = 1'b1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        @(negedge clk);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        n_cmp++;
        if (bus.sample_valid !== 1'b1 || bus.sample_data !== rom_word(6'd0) || busy !== 1'b1) begin
            n_err++; $display("FAIL stop_cap_deliver: got valid=%b data=%h busy=%b want 1/%h/1", bus.sample_valid, bus.sample_data, busy, rom_word(6'd0));
        end
        @(negedge clk);
        n_cmp++;
        if (bus.sample_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL stop_cap_idle: got valid=%b busy=%b want 0/0", bus.sample_valid, busy);
        end
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            tick = (k % 4 == 0);
            @(negedge clk);
            tick = 1'b0;
            if (bus.rom_en !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin n_err++; $display("FAIL stop_cap_no_read: got %0d rom_en cycles want 0", stray); end
        start = 1'b1; @(negedge clk); start = 1'b0;
        tick = 1'b1; stop = 1'b1; @(negedge clk); tick = 1'b0; stop = 1'b0;
        n_cmp++;
        if (bus.rom_en !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL stop_tick_armed: got en=%b busy=%b want 0/0", bus.rom_en, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rom_en !== 1'b0) begin n_err++; $display("FAIL stop_tick_armed2: got en=%b want 0", bus.rom_en); end
    endtask

    task automatic test_async_reset();
        step = 16'h0400;
        bus.sample_ready = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.sample_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_hold: got valid=%b want 1", bus.sample_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rom_en, bus.rom_address, bus.sample_data, bus.sample_valid, busy, overrun} !== '0) begin
            n_err++;
            $display("FAIL arst_outputs: got en=%b addr=%0d data=%h valid=%b busy=%b ovr=%b want all 0",
                     bus.rom_en, bus.rom_address, bus.sample_data, bus.sample_valid, busy, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.sample_ready = 1'b1;
        step = 16'h0C00;
        start = 1'b1; @(negedge clk); start = 1'b0;
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        n_cmp++;
        if (bus.rom_en !== 1'b1 || bus.rom_address !== 6'd0) begin
            n_err++; $display("FAIL arst_restart: got en=%b addr=%0d want 1/0", bus.rom_en, bus.rom_address);
        end
        repeat (3) @(negedge clk);
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        n_cmp++;
        if (bus.rom_address !== 6'd3) begin n_err++; $display("FAIL arst_second: got addr=%0d want 3", bus.rom_address); end
        repeat (3) @(negedge clk);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

`ifdef SINE_BURST_EN
    task automatic test_burst();
        int hs;
        int done_cnt;
        step = 16'h0400;
        bus.sample_ready = 1'b1;
        burst_len = 16'd3;
        start = 1'b1; @(negedge clk); start = 1'b0;
        burst_len = 16'd7;
        hs = 0;
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0;
            repeat (2) @(negedge clk);
            if (bus.sample_valid === 1'b1) hs++;
            @(negedge clk);
            if (k == 2) begin
                n_cmp++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    n_err++; $display("FAIL burst_done: got done=%b busy=%b want 1/0", done, busy);
                end
            end
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        n_cmp++;
        if (hs != 3 || done_cnt != 1) begin
            n_err++; $display("FAIL burst_count: got hs=%0d done=%0d want 3/1", hs, done_cnt);
        end
        burst_len = 16'd0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0;
            repeat (3) @(negedge clk);
            if (done === 1'b1 || busy !== 1'b1) done_cnt++;
        end
        n_cmp++;
        if (done_cnt != 0) begin n_err++; $display("FAIL burst_unlimited: got %0d bad cycles want 0", done_cnt); end
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL burst_stop: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_stop();
        test_async_reset();
`ifdef SINE_BURST_EN
        test_burst();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
